// File: rtl/spi_minion.sv
// SPI mode-0 minion: synchronizes cs/sclk/mosi into clk, shifts words MSB first,
// and bridges them to a val/rdy send stream (rx) and a val/rdy recv stream (tx).
module spi_minion #(
  parameter int nbits = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cs,
  input  logic             sclk,
  input  logic             mosi,
  output logic             miso,
  input  logic [nbits-1:0] recv_msg,
  input  logic             recv_val,
  output logic             recv_rdy,
  output logic [nbits-1:0] send_msg,
  output logic             send_val,
  input  logic             send_rdy,
  output logic             overflow
);

  localparam int CW = $clog2(nbits + 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t           state_q, state_d;
  logic [2:0]       cs_s, sclk_s;
  logic [1:0]       mosi_s;
  logic [nbits-1:0] shift_reg, tx_buf, word;
  logic [CW-1:0]    bit_cnt;
  logic             tx_full, rx_bit;
  logic             cs_fall, cs_rise, sclk_rise, sclk_fall;
  logic             word_start, do_sample, do_shift, word_done, send_free;

  // Two sync flops, third stage only feeds the edge detectors
  always_ff @(posedge clk) begin
    if (!reset) begin
      cs_s   <= 3'b111;
      sclk_s <= 3'b000;
      mosi_s <= 2'b00;
    end else begin
      cs_s   <= {cs_s[1:0], cs};
      sclk_s <= {sclk_s[1:0], sclk};
      mosi_s <= {mosi_s[0], mosi};
    end
  end

  assign cs_fall   =  cs_s[2]   & ~cs_s[1];
  assign cs_rise   = ~cs_s[2]   &  cs_s[1];
  assign sclk_rise = ~sclk_s[2] &  sclk_s[1];
  assign sclk_fall =  sclk_s[2] & ~sclk_s[1];

  assign recv_rdy  = !tx_full;
  assign word      = {shift_reg[nbits-2:0], rx_bit};
  assign send_free = !send_val || send_rdy;

  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cs_fall) state_d = ACTIVE;
      ACTIVE:  if (cs_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // cs rising masks any sclk edge in the same cycle, so the word is discarded
  always_comb begin
    word_start = 1'b0;
    do_sample  = 1'b0;
    do_shift   = 1'b0;
    word_done  = 1'b0;
    case (state_q)
      IDLE: word_start = cs_fall;
      ACTIVE: if (!cs_rise) begin
        do_sample  = sclk_rise;
        do_shift   = sclk_fall;
        word_done  = sclk_fall && (bit_cnt == CW'(nbits - 1));
        word_start = word_done;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      miso      <= 1'b0;
      send_msg  <= '0;
      send_val  <= 1'b0;
      overflow  <= 1'b0;
      tx_full   <= 1'b0;
      tx_buf    <= '0;
      shift_reg <= '0;
      bit_cnt   <= '0;
      rx_bit    <= 1'b0;
    end else begin
      miso     <= (state_q == ACTIVE && state_d == ACTIVE) ? shift_reg[nbits-1] : 1'b0;
      overflow <= 1'b0;
      if (word_start) begin
        shift_reg <= tx_full ? tx_buf : '0;
        tx_full   <= 1'b0;
        bit_cnt   <= '0;
      end else if (do_shift) begin
        shift_reg <= word;
        bit_cnt   <= bit_cnt + CW'(1);
      end
      if (do_sample) rx_bit <= mosi_s[1];
      // Load after the start so a same-cycle start consumes the old buffer
      if (recv_val && !tx_full) begin
        tx_buf  <= recv_msg;
        tx_full <= 1'b1;
      end
      if (send_val && send_rdy) send_val <= 1'b0;
      if (word_done) begin
        if (send_free) begin
          send_msg <= word;
          send_val <= 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/spi_minion.md
Name: spi_minion

Overview:
- SPI mode-0 peripheral (minion): the far end of our SPI master. Serves the master's cs/sclk/mosi and drives miso.
- Presents received words on a val/rdy send stream.
- Accepts words to transmit on a val/rdy recv stream.
- All SPI inputs are asynchronous to clk. They are synchronized internally and sampled on detected edges, so clk must be much faster than sclk.

Parameters:
nbits  8  SPI word width in bits; MSB first on both mosi and miso.

Ports:
clk        input   1      system clock; all state updates on rising edge
reset      input   1      synchronous, active-low reset; asserted when 0, sampled on clk rising edge
cs         input   1      chip select from master, active low, async
sclk       input   1      SPI clock from master, idle low (CPOL=0), async
mosi       input   1      serial data from master, async
miso       output  1      serial data to master, registered
recv_msg   input   nbits  word to shift out on the next transfer
recv_val   input   1      recv_msg valid
recv_rdy   output  1      tx buffer empty, can accept recv_msg
send_msg   output  nbits  last complete word received from master
send_val   output  1      send_msg valid
send_rdy   input   1      consumer accepts send_msg
overflow   output  1      1-cycle pulse: completed word dropped because the send buffer was full

Behaviour:
- Synchronization: cs, sclk, mosi each pass through 2 flops, plus a third stage for edge detect.
  - Reset values: cs stages 1, sclk stages 0, mosi stages 0.
  - Edge-to-action latency is 3 clk cycles.
  - Requirements on the master: sclk high and low phases each ≥4 clk cycles; cs-low to first sclk rise ≥4 clk cycles.
- Reset (reset==0 on a clk edge) sets:
  - state=IDLE; miso=0; send_val=0; send_msg=0; overflow=0.
  - tx_full=0, so recv_rdy=1; shift_reg=0; bit_cnt=0.
  - Reset mid-transfer aborts the transfer; the partial word is lost and the tx buffer is cleared.
- recv stream:
  - recv_rdy = !tx_full, combinational.
  - recv_val && recv_rdy: tx_buf<=recv_msg, tx_full<=1.
- send stream:
  - send_msg/send_val are held stable until send_rdy && send_val; then send_val<=0.
- State IDLE:
  - miso=0.
  - On synced cs falling edge, word start: shift_reg<=tx_full ? tx_buf : 0; tx_full<=0; bit_cnt<=0; state->ACTIVE.
  - Empty tx buffer at word start transmits all zeros; no error flag.
- State ACTIVE:
  - miso=shift_reg[nbits-1], registered.
  - Synced sclk rising edge: rx_bit<=mosi_sync. Mode-0 sample.
  - Synced sclk falling edge: shift_reg<={shift_reg[nbits-2:0], rx_bit}; bit_cnt<=bit_cnt+1. miso therefore advances after the falling edge.
  - bit_cnt width is $clog2(nbits+1); it never wraps, because it resets at word completion.
- Word completion (the falling edge that makes bit_cnt==nbits):
  - Received word = {shift_reg[nbits-2:0], rx_bit}.
  - If send buffer is free (!send_val, or send_val&&send_rdy this cycle): send_msg<=word, send_val<=1.
  - Otherwise overflow=1 for that one cycle, and the word is dropped; send_msg is unchanged.
  - If cs is still low: a new word starts in the same cycle, with the same reload rule (tx_buf if tx_full, else 0). This gives back-to-back words under one cs.
- Synced cs rising edge while ACTIVE:
  - state->IDLE; miso<=0; partial word discarded; no send_val, no overflow.
  - A loaded tx word already consumed by this transfer is not restored.
- Simultaneous events:
  - recv handshake in the same cycle as word start: start uses the old tx_buf/tx_full. The new word is stored, and tx_full ends at 1.
  - cs rising and sclk falling in the same cycle: cs wins and the word is discarded.
- No tristate: miso is driven 0 while idle.

Test Plan:
1. nbits=8; recv 0xA5 before cs falls; master sends 0x3C. Required: miso bits 1,0,1,0,0,1,0,1; send_val=1 with send_msg=0x3C; recv_rdy returns to 1 at cs fall.
2. No recv word loaded; master sends 0xFF. Required: miso all 0; send_msg=0xFF; overflow stays 0.
3. send_rdy held 0; two words 0x11 then 0x22 under one cs. Required: send_msg=0x11 with send_val=1; one-cycle overflow pulse at the second completion; send_msg still 0x11.
4. cs raised after 5 sclk cycles, then full transfer of 0x81. Required: no send_val from the aborted word; next send_msg=0x81.
5. send_val=1 (0x11) and send_rdy=1 in the exact cycle the next word 0x22 completes. Required: send_msg=0x22, send_val stays 1, no overflow.
6. reset=0 for one cycle mid-transfer with tx_full=1. Required: miso=0, send_val=0, recv_rdy=1, state IDLE; subsequent transfer of 0x5A works.
